// File: rtl/snake_tick_gen.sv
// Game-tick generator: divides clk by 2^(DIV_LOG2-level) and emits a one-cycle
// tick enable plus a 50%-duty snake_clk. Level moves by buttons and score.
module snake_tick_gen #(
  parameter int DIV_LOG2        = 25,
  parameter int NUM_LEVELS      = 4,
  parameter int LEVEL_W         = 2,
  parameter int SCORE_PER_LEVEL = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               speed_up,
  input  logic               speed_down,
  input  logic               pause,
  input  logic               score,
  output logic [LEVEL_W-1:0] level,
  output logic               tick,
  output logic               snake_clk,
  output logic               paused
);

  // All inputs are single-cycle pulses except pause, which is level-sensitive;
  // there is no valid/ready handshake on this block.
  localparam logic [LEVEL_W-1:0] MAX_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
  localparam int SC_W = (SCORE_PER_LEVEL > 1) ? $clog2(SCORE_PER_LEVEL) : 1;
  localparam logic [SC_W-1:0] SC_LAST =
    SC_W'((SCORE_PER_LEVEL > 0) ? SCORE_PER_LEVEL - 1 : 0);

  logic [DIV_LOG2-1:0] cnt;
  logic [DIV_LOG2-1:0] mask;
  logic [DIV_LOG2-1:0] half;
  logic [SC_W-1:0]     score_cnt;
  logic [LEVEL_W-1:0]  level_nxt;
  logic                score_ok;
  logic                auto_up;
  logic                up_req;
  logic                dn_req;
  logic                lvl_change;

  always_comb begin
    mask       = {DIV_LOG2{1'b1}} >> level;
    // single bit at position DIV_LOG2-1-level: the square-wave source bit
    half       = mask ^ (mask >> 1);
    score_ok   = score && !pause;
    auto_up    = (SCORE_PER_LEVEL != 0) && score_ok && (score_cnt == SC_LAST);
    up_req     = speed_up || auto_up;
    dn_req     = speed_down;
    level_nxt  = level;
    if (up_req && !dn_req && (level != MAX_LEVEL)) begin
      level_nxt = level + LEVEL_W'(1);
    end else if (dn_req && !up_req && (level != '0)) begin
      level_nxt = level - LEVEL_W'(1);
    end
    lvl_change = (level_nxt != level);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      level     <= '0;
      score_cnt <= '0;
      tick      <= 1'b0;
      snake_clk <= 1'b0;
      paused    <= 1'b0;
    end else begin
      paused <= pause;
      level  <= level_nxt;
      if (score_ok && (SCORE_PER_LEVEL != 0)) begin
        score_cnt <= (score_cnt == SC_LAST) ? '0 : score_cnt + SC_W'(1);
      end
      // An effective level change restarts the period from phase zero.
      if (lvl_change) begin
        cnt       <= '0;
        tick      <= 1'b0;
        snake_clk <= 1'b0;
      end else begin
        tick <= !pause && ((cnt & mask) == mask);
        if (!pause) begin
          cnt       <= cnt + DIV_LOG2'(1);
          snake_clk <= |(cnt & half);
        end
      end
    end
  end

endmodule

// File: tb/tb_snake_tick_gen.sv
// Bench for snake_tick_gen: directed scenarios plus random traffic, all checked
// against an integer phase/period model of the tick generator.
module tb_snake_tick_gen;

  localparam int DIV_LOG2   = 6;
  localparam int NUM_LEVELS = 4;
  localparam int LEVEL_W    = 2;
  localparam int SPL        = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               speed_up;
  logic               speed_down;
  logic               pause;
  logic               score;
  logic [LEVEL_W-1:0] level;
  logic               tick;
  logic               snake_clk;
  logic               paused;

  snake_tick_gen #(
    .DIV_LOG2(DIV_LOG2), .NUM_LEVELS(NUM_LEVELS),
    .LEVEL_W(LEVEL_W), .SCORE_PER_LEVEL(SPL)
  ) dut (
    .clk(clk), .rst(rst), .speed_up(speed_up), .speed_down(speed_down),
    .pause(pause), .score(score), .level(level), .tick(tick),
    .snake_clk(snake_clk), .paused(paused)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // reference model: phase = unpaused cycles since the last clear
  int m_level, m_phase, m_score;
  int m_tick, m_sclk, m_paused;

  // scoreboard of expected tick cycle numbers
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    m_level = 0; m_phase = 0; m_score = 0;
    m_tick = 0; m_sclk = 0; m_paused = 0;
  endtask

  task automatic model_step();
    int period, target, pos;
    bit auto_up, up_r, dn_r;
    period  = 1 << (DIV_LOG2 - m_level);
    auto_up = !pause && score && (m_score == SPL - 1);
    if (!pause && score) m_score = (m_score + 1) % SPL;
    up_r = speed_up || auto_up;
    dn_r = speed_down;
    target = m_level;
    if (up_r && !dn_r) target = (m_level + 1 > NUM_LEVELS - 1) ? NUM_LEVELS - 1 : m_level + 1;
    if (dn_r && !up_r) target = (m_level == 0) ? 0 : m_level - 1;
    m_paused = int'(pause);
    if (target != m_level) begin
      m_level = target; m_phase = 0; m_tick = 0; m_sclk = 0;
    end else begin
      pos    = m_phase % period;
      m_tick = (!pause && pos == period - 1) ? 1 : 0;
      if (!pause) begin
        m_sclk  = (pos >= period / 2) ? 1 : 0;
        m_phase = (m_phase + 1) % (1 << DIV_LOG2);
      end
    end
  endtask

  // driver: one clock with the currently applied inputs, then compare
  task automatic cycle();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    check("level", 32'(level), 32'(m_level));
    check("tick", 32'(tick), 32'(m_tick));
    check("snake_clk", 32'(snake_clk), 32'(m_sclk));
    check("paused", 32'(paused), 32'(m_paused));
    if (tick === 1'b1 && exp_q.size() > 0) check("tick_time", 32'(cyc), exp_q.pop_front());
    speed_up = 1'b0; speed_down = 1'b0; score = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drained(input string tag);
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // asynchronous reset asserted away from any clock edge
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_sclk", 32'(snake_clk), 32'd0);
    check("rst_paused", 32'(paused), 32'd0);
    speed_up = 1'b0; speed_down = 1'b0; score = 1'b0; pause = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc = 0;
  endtask

  initial begin
    rst = 1'b1; speed_up = 1'b0; speed_down = 1'b0; pause = 1'b0; score = 1'b0;
    model_reset();

    // free run at level 0
    do_reset();
    exp_q.push_back(32'd64); exp_q.push_back(32'd128); exp_q.push_back(32'd192);
    run(200);
    drained("free_run_ticks");

    // five speed_up pulses: 1,2,3,3,3
    do_reset();
    for (int i = 0; i < 5; i++) begin
      speed_up = 1'b1;
      cycle();
      check("up_seq", 32'(level), 32'((i + 1 > 3) ? 3 : i + 1));
      run(3);
    end
    run(40);

    // simultaneous up+down at level 2, then three downs
    do_reset();
    speed_up = 1'b1; cycle();
    speed_up = 1'b1; cycle();
    run(5);
    speed_up = 1'b1; speed_down = 1'b1; cycle();
    check("updown_hold", 32'(level), 32'd2);
    run(20);
    for (int i = 0; i < 3; i++) begin
      speed_down = 1'b1;
      cycle();
      check("down_seq", 32'(level), 32'((1 - i < 0) ? 0 : 1 - i));
      run(2);
    end

    // auto raise by score, then score + manual up counts once
    do_reset();
    for (int i = 0; i < 3; i++) begin
      score = 1'b1; cycle(); run(1);
    end
    check("auto_level", 32'(level), 32'd1);
    exp_q.push_back(32'(cyc - 1 + 32));
    run(40);
    drained("auto_first_tick");
    score = 1'b1; cycle();
    score = 1'b1; cycle();
    score = 1'b1; speed_up = 1'b1; cycle();
    check("score_plus_up", 32'(level), 32'd2);
    run(10);

    // pause across a due level-0 tick, with ignored score pulses
    do_reset();
    run(54);
    pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      score = (i % 4 == 1) ? 1'b1 : 1'b0;
      cycle();
    end
    pause = 1'b0;
    exp_q.push_back(32'd84);
    run(20);
    drained("pause_resume_tick");
    check("pause_score_ignored", 32'(level), 32'd0);

    // reset mid-period at level 2
    do_reset();
    speed_up = 1'b1; cycle();
    speed_up = 1'b1; cycle();
    run(7);
    do_reset();
    exp_q.push_back(32'd64);
    run(70);
    drained("post_reset_tick");

    // random traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      speed_up   = ($urandom_range(0, 19) == 0);
      speed_down = ($urandom_range(0, 24) == 0);
      score      = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) pause = ~pause;
      cycle();
    end
    pause = 1'b0;
    run(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
